// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with architectural HI/LO for the MIPS pipeline.
// Operands are latched on Start; the result is formed from the latches and committed once the latency expires.
//
//   state  | meaning
//   S_IDLE | no operation in flight, Start accepted
//   S_BUSY | mult/div in flight, cnt_q counts the remaining cycles
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        mul_sgn, div_sgn, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, quo_mag, rem_mag, quo, rem;

  // The low 64 bits of the sign/zero-extended product are correct for both mult and multu.
  always_comb begin
    mul_sgn = (op_q == OP_MULT);
    a_ext   = {{32{mul_sgn & a_q[31]}}, a_q};
    b_ext   = {{32{mul_sgn & b_q[31]}}, b_q};
    prod    = a_ext * b_ext;
  end

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    div_sgn = (op_q == OP_DIV);
    a_neg   = div_sgn & a_q[31];
    b_neg   = div_sgn & b_q[31];
    a_mag   = a_neg ? (32'd0 - a_q) : a_q;
    b_mag   = b_neg ? (32'd0 - b_q) : b_q;
    quo_mag = a_mag / b_mag;
    rem_mag = a_mag % b_mag;
    quo     = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    rem     = a_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              op_d    = MDOp;
              a_d     = A;
              b_d     = B;
              cnt_d   = 8'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = MDOp;
              a_d     = A;
              b_d     = B;
              cnt_d   = 8'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT, OP_MULTU: begin
              hi_d = prod[63:32];
              lo_d = prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
              if (b_q != 32'd0) begin
                hi_d = rem;
                lo_d = quo;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= 8'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a 64-bit integer arithmetic model of HI/LO.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Returns {HI,LO} after the operation; divide by zero leaves cur untouched.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
    int ia, ib;
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    ia = int'(a);
    ib = int'(b);
    sa = longint'(ia);
    sb = longint'(ib);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 32'd0) return cur;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return cur;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return cur;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inj);
    int n, exp_cycles;
    bit stable;
    logic [63:0] res;
    res = ref_md(op, a, b, {hi_m, lo_m});
    exp_cycles = (op <= 3'd2) ? MC : DC;
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    check_eq($sformatf("op%0d_busy_at_start", op), 64'(Busy), 64'(0));
    tick();
    Start = 1'b0;
    MDOp  = 3'($urandom);
    A     = $urandom;
    B     = $urandom;
    n = 0;
    stable = 1'b1;
    while (Busy && n < 300) begin
      if (HI !== hi_m || LO !== lo_m) stable = 1'b0;
      if (inj && n == 2) begin
        Start = 1'b1;
        MDOp  = 3'd5;
        A     = 32'hDEADBEEF;
      end
      tick();
      Start = 1'b0;
      n++;
    end
    check_eq($sformatf("op%0d_busy_cycles", op), 64'(n), 64'(exp_cycles));
    check_eq($sformatf("op%0d_hold_while_busy", op), 64'(stable), 64'(1));
    hi_m = res[63:32];
    lo_m = res[31:0];
    check_eq($sformatf("op%0d_hi a=%h b=%h", op, a, b), 64'(HI), 64'(hi_m));
    check_eq($sformatf("op%0d_lo a=%h b=%h", op, a, b), 64'(LO), 64'(lo_m));
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = $urandom;
    tick();
    Start = 1'b0;
    A     = $urandom;
    if (op == 3'd5) hi_m = a;
    else lo_m = a;
    check_eq($sformatf("mt%0d_busy", op), 64'(Busy), 64'(0));
    check_eq($sformatf("mt%0d_hi", op), 64'(HI), 64'(hi_m));
    check_eq($sformatf("mt%0d_lo", op), 64'(LO), 64'(lo_m));
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit quiet;
    logic [2:0] op;
    logic [31:0] a, b;

    reset = 1'b0;
    A = $urandom;
    B = $urandom;
    tick();
    tick();
    check_eq("rst_busy", 64'(Busy), 64'(0));
    check_eq("rst_hi", 64'(HI), 64'(0));
    check_eq("rst_lo", 64'(LO), 64'(0));
    reset = 1'b1;
    tick();

    run_md(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    check_eq("plan_mult_hi", 64'(HI), 64'(32'hFFFFFFFF));
    check_eq("plan_mult_lo", 64'(LO), 64'(32'hFFFFFFF1));
    run_md(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    check_eq("plan_multu_hi", 64'(HI), 64'(32'h00000001));
    check_eq("plan_multu_lo", 64'(LO), 64'(32'hFFFFFFFE));
    run_md(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check_eq("plan_div_lo", 64'(LO), 64'(32'hFFFFFFFD));
    run_md(3'd4, 32'd7, 32'd2, 1'b0);
    run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check_eq("plan_divovf_lo", 64'(LO), 64'(32'h80000000));
    check_eq("plan_divovf_hi", 64'(HI), 64'(0));

    run_mt(3'd5, 32'h11111111);
    run_mt(3'd6, 32'h22222222);
    run_md(3'd4, 32'd7, 32'd0, 1'b1);
    check_eq("plan_div0_hi", 64'(HI), 64'(32'h11111111));
    check_eq("plan_div0_lo", 64'(LO), 64'(32'h22222222));

    // Abort a mult in its third busy cycle.
    Start = 1'b1;
    MDOp  = 3'd1;
    A     = 32'd3;
    B     = 32'd4;
    tick();
    Start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    check_eq("midrst_busy", 64'(Busy), 64'(0));
    check_eq("midrst_hi", 64'(HI), 64'(0));
    check_eq("midrst_lo", 64'(LO), 64'(0));
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) quiet = 1'b0;
    end
    check_eq("midrst_no_late_write", 64'(quiet), 64'(1));
    run_md(3'd1, 32'd3, 32'd4, 1'b0);
    check_eq("postrst_lo", 64'(LO), 64'(12));

    run_md(3'd1, 32'd2, 32'd3, 1'b0);
    run_md(3'd3, 32'd9, 32'd4, 1'b0);
    check_eq("b2b_lo", 64'(LO), 64'(2));
    check_eq("b2b_hi", 64'(HI), 64'(1));

    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(1, 6));
      a  = pick_val();
      b  = pick_val();
      if (op >= 3'd3 && $urandom_range(0, 7) == 0) b = 32'd0;
      if (op >= 3'd5) run_mt(op, a);
      else run_md(op, a, b, ($urandom_range(0, 3) == 0));
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        MDOp = 3'($urandom);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
